// File: rtl/audio_hit_detector.sv
// Envelope-follower hit detector: rectifies the left ADC channel, tracks a peak/decay envelope
// and emits one pulse per threshold crossing, with hysteresis and a minimum holdoff between hits.
module audio_hit_detector #(
  parameter logic [15:0] THRESH_ON      = 16'd8000,
  parameter logic [15:0] THRESH_OFF     = 16'd4000,
  parameter int unsigned HOLDOFF_CYCLES = 2500000,
  parameter int unsigned DECAY_SHIFT    = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_count,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [15:0] level,
  output logic        hit,
  output logic [7:0]  hit_count,
  output logic        armed
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [15:0]      mag_q, mag_d;
  logic             v1_q, v1_d;
  logic [15:0]      env_q, env_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [7:0]       count_q, count_d;

  logic        consume;
  logic [15:0] sample_hi;
  logic [15:0] sample_abs;
  logic [15:0] decay_raw;
  logic [15:0] decay_amt;
  logic        unused_bits;

  // Only the upper half of the left sample carries the audio we care about.
  assign unused_bits = ^{right_channel_audio_in, left_channel_audio_in[15:0]};

  assign consume       = audio_in_available & enable & ~reset;
  assign read_audio_in = consume;
  assign sample_hi     = left_channel_audio_in[31:16];

  // -32768 has no positive twin in 16 bits, so it clips to full scale.
  always_comb begin
    sample_abs = sample_hi;
    if (sample_hi == 16'h8000) begin
      sample_abs = 16'h7FFF;
    end else if (sample_hi[15]) begin
      sample_abs = (~sample_hi) + 16'd1;
    end
  end

  // Stage 1: rectified magnitude
  always_comb begin
    mag_d = mag_q;
    v1_d  = consume;
    if (!enable) begin
      mag_d = 16'd0;
      v1_d  = 1'b0;
    end else if (consume) begin
      mag_d = sample_abs;
    end
  end

  // Decay always moves by at least one LSB so small envelopes still reach zero.
  always_comb begin
    decay_raw = env_q >> DECAY_SHIFT;
    decay_amt = (decay_raw == 16'd0) ? 16'd1 : decay_raw;
  end

  // Stage 2: peak-hold with proportional decay, advancing only on valid samples
  always_comb begin
    env_d = env_q;
    if (!enable) begin
      env_d = 16'd0;
    end else if (v1_q) begin
      if (mag_q > env_q) begin
        env_d = mag_q;
      end else if (env_q != 16'd0) begin
        env_d = env_q - decay_amt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (env_q >= THRESH_ON) begin
            state_d = ST_HOLDOFF;
            hit_d   = 1'b1;
            cnt_d   = HOLD_LOAD;
          end
        end
        ST_HOLDOFF: begin
          // Re-arm needs both the time window elapsed and the envelope back below hysteresis.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (env_q < THRESH_OFF) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_count) begin
      count_d = hit_d ? 8'd1 : 8'd0;
    end else if (hit_d && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mag_q   <= 16'd0;
      v1_q    <= 1'b0;
      env_q   <= 16'd0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      v1_q    <= v1_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      count_q <= count_d;
    end
  end

  assign level     = env_q;
  assign hit       = hit_q;
  assign hit_count = count_q;
  assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_audio_hit_detector.sv
// Directed bench for audio_hit_detector with a short holdoff window.
module tb_audio_hit_detector;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic        clear_count;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic [15:0] level;
  logic        hit;
  logic [7:0]  hit_count;
  logic        armed;

  int checks;
  int failures;
  int hits_seen;

  audio_hit_detector #(
    .THRESH_ON(16'd8000),
    .THRESH_OFF(16'd4000),
    .HOLDOFF_CYCLES(8),
    .DECAY_SHIFT(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .enable(enable),
    .clear_count(clear_count),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .read_audio_in(read_audio_in),
    .level(level),
    .hit(hit),
    .hit_count(hit_count),
    .armed(armed)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One consume of a sample whose upper half is hi, then idle until the envelope reflects it.
  task automatic feed(input logic [31:0] word);
    audio_in_available    = 1'b1;
    left_channel_audio_in = word;
    step();
    audio_in_available    = 1'b0;
    step();
  endtask

  // Re-arm via enable toggle, then drive one loud sample through to its hit pulse.
  task automatic quick_hit();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    feed({16'd10000, 16'h0000});
    step();
  endtask

  initial begin
    checks                 = 0;
    failures               = 0;
    hits_seen              = 0;
    reset                  = 1'b1;
    enable                 = 1'b1;
    clear_count            = 1'b0;
    audio_in_available     = 1'b1;
    left_channel_audio_in  = 32'h0;
    right_channel_audio_in = 32'h7FFF_FFFF;
    step();
    step();
    chk("rst_read", {31'd0, read_audio_in}, 32'd0);
    chk("rst_level", {16'd0, level}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_count", {24'd0, hit_count}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);

    reset              = 1'b0;
    audio_in_available = 1'b0;
    #1;
    chk("idle_armed", {31'd0, armed}, 32'd0);
    step();
    chk("armed_after_en", {31'd0, armed}, 32'd1);

    // Ten silent samples back to back
    audio_in_available    = 1'b1;
    left_channel_audio_in = 32'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hit) hits_seen++;
    end
    audio_in_available = 1'b0;
    step();
    if (hit) hits_seen++;
    step();
    if (hit) hits_seen++;
    chk("zero_hits", hits_seen, 32'd0);
    chk("zero_level", {16'd0, level}, 32'd0);
    chk("zero_armed", {31'd0, armed}, 32'd1);

    // First hit
    audio_in_available    = 1'b1;
    left_channel_audio_in = 32'h2710_0000;
    #1;
    chk("read_strobe", {31'd0, read_audio_in}, 32'd1);
    step();
    audio_in_available = 1'b0;
    step();
    chk("lvl_10000", {16'd0, level}, 32'd10000);
    chk("no_hit_yet", {31'd0, hit}, 32'd0);
    step();
    chk("hit1", {31'd0, hit}, 32'd1);
    chk("count1", {24'd0, hit_count}, 32'd1);
    chk("holdoff1", {31'd0, armed}, 32'd0);
    step();
    chk("hit1_pulse", {31'd0, hit}, 32'd0);

    // Counter long expired but envelope still high
    for (int i = 0; i < 12; i++) step();
    chk("hold_env_high", {31'd0, armed}, 32'd0);
    chk("env_held", {16'd0, level}, 32'd10000);

    // Fourteen zeros: 10000 decays to 4055
    audio_in_available    = 1'b1;
    left_channel_audio_in = 32'h0;
    for (int i = 0; i < 14; i++) step();
    audio_in_available = 1'b0;
    step();
    step();
    chk("lvl_4055", {16'd0, level}, 32'd4055);
    chk("still_hold", {31'd0, armed}, 32'd0);
    feed(32'h0);
    chk("lvl_3802", {16'd0, level}, 32'd3802);
    chk("hold_edge", {31'd0, armed}, 32'd0);
    step();
    chk("rearmed", {31'd0, armed}, 32'd1);

    feed(32'h2710_0000);
    chk("lvl2_10000", {16'd0, level}, 32'd10000);
    step();
    chk("hit2", {31'd0, hit}, 32'd1);
    chk("count2", {24'd0, hit_count}, 32'd2);

    feed(32'h8000_0000);
    chk("lvl_sat", {16'd0, level}, 32'd32767);

    // Disable while in holdoff
    audio_in_available = 1'b1;
    enable             = 1'b0;
    #1;
    chk("dis_read", {31'd0, read_audio_in}, 32'd0);
    step();
    audio_in_available = 1'b0;
    chk("dis_armed", {31'd0, armed}, 32'd0);
    chk("dis_level", {16'd0, level}, 32'd0);
    chk("dis_count", {24'd0, hit_count}, 32'd2);
    chk("dis_hit", {31'd0, hit}, 32'd0);

    enable = 1'b1;
    step();
    chk("reen_armed", {31'd0, armed}, 32'd1);
    feed({16'd10, 16'hFFFF});
    chk("lvl_10", {16'd0, level}, 32'd10);
    for (int e = 9; e >= 0; e--) begin
      feed(32'h0);
      chk("decay_step", {16'd0, level}, e);
    end
    feed(32'h0);
    chk("decay_floor", {16'd0, level}, 32'd0);

    // Negative sample -20000
    feed(32'hB1E0_1234);
    chk("lvl_neg", {16'd0, level}, 32'd20000);
    step();
    chk("hit3", {31'd0, hit}, 32'd1);
    chk("count3", {24'd0, hit_count}, 32'd3);

    for (int i = 0; i < 252; i++) quick_hit();
    chk("count255", {24'd0, hit_count}, 32'd255);
    quick_hit();
    chk("sat_hit", {31'd0, hit}, 32'd1);
    chk("sat_count", {24'd0, hit_count}, 32'd255);

    // Clear in the same cycle as an increment
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    feed({16'd10000, 16'h0000});
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    chk("clr_hit", {31'd0, hit}, 32'd1);
    chk("clr_inc", {24'd0, hit_count}, 32'd1);
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    chk("clr_only", {24'd0, hit_count}, 32'd0);

    // Reset with a loud sample in flight
    quick_hit();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    audio_in_available    = 1'b1;
    left_channel_audio_in = {16'd20000, 16'h0};
    step();
    audio_in_available = 1'b0;
    reset              = 1'b1;
    step();
    reset     = 1'b0;
    hits_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (hit) hits_seen++;
    end
    chk("rst_flush_lvl", {16'd0, level}, 32'd0);
    chk("rst_flush_hit", hits_seen, 32'd0);
    chk("rst_flush_armed", {31'd0, armed}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_hit_detector.md
AUDIO_HIT_DETECTOR -- requirements
Module: audio_hit_detector

Interface
REQ-001 Parameter THRESH_ON, default 16'd8000: envelope level at or above which a hit SHALL be declared.
REQ-002 Parameter THRESH_OFF, default 16'd4000: envelope level below which the detector SHALL re-arm; THRESH_OFF < THRESH_ON.
REQ-003 Parameter HOLDOFF_CYCLES, default 2500000: minimum clock cycles between hits (50 ms at 50 MHz).
REQ-004 Parameter DECAY_SHIFT, default 4: envelope decay shift per consumed sample.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 CLOCK_50  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  detector on; low forces IDLE.
REQ-009 clear_count  input  1  single-cycle pulse clearing hit_count.
REQ-010 audio_in_available  input  1  Audio_Controller has an ADC sample pair ready.
REQ-011 left_channel_audio_in  input  32  signed mic sample, left.
REQ-012 right_channel_audio_in  input  32  signed mic sample, right; unused, SHALL be ignored.
REQ-013 read_audio_in  output  1  consume strobe to Audio_Controller.
REQ-014 level  output  16  current envelope, unsigned.
REQ-015 hit  output  1  one-cycle pulse per detected hit.
REQ-016 hit_count  output  8  saturating hit counter.
REQ-017 armed  output  1  high while in ARMED state.

Function
REQ-018 read_audio_in SHALL equal audio_in_available AND enable AND NOT reset, combinationally; a sample is consumed in any cycle where read_audio_in is high.
REQ-019 Stage 1: cycle after consume, mag register SHALL take |left_channel_audio_in[31:16]|; -32768 SHALL saturate to 32767.
REQ-020 Stage 2: cycle after stage 1, if mag > env then env <= mag; else if env > 0 then env <= env - max(env >> DECAY_SHIFT, 1); else env holds.
REQ-021 level SHALL equal env; latency consume -> level update = 2 cycles; env SHALL NOT change in cycles without a stage-2 valid.
REQ-022 Back-to-back consumes SHALL be accepted every cycle with no sample dropped.
REQ-023 FSM states: IDLE, ARMED, HOLDOFF.
REQ-024 IDLE -> ARMED when enable high; any state -> IDLE the cycle after enable low; env, mag and in-flight pipeline valids SHALL clear on entry to IDLE; hit_count holds.
REQ-025 ARMED: when env >= THRESH_ON, the next cycle SHALL assert hit for exactly 1 cycle, increment hit_count, load holdoff counter with HOLDOFF_CYCLES-1, enter HOLDOFF.
REQ-026 HOLDOFF: counter decrements by 1 per cycle, stops at 0; -> ARMED only when counter == 0 AND env < THRESH_OFF; counter 0 with env >= THRESH_OFF SHALL remain in HOLDOFF.
REQ-027 hit SHALL never assert outside the ARMED -> HOLDOFF transition; no two hits closer than HOLDOFF_CYCLES+1 cycles.
REQ-028 hit_count SHALL saturate at 255 (no wrap); hit continues to pulse at saturation.
REQ-029 clear_count and an increment in the same cycle: hit_count SHALL become 1; clear alone -> 0.
REQ-030 armed SHALL be high exactly while state == ARMED.

Reset
REQ-031 On reset high at a clock edge: state IDLE, env 0, mag 0, pipeline valids 0, holdoff counter 0, hit_count 0, hit 0, armed 0, level 0; read_audio_in 0 while reset high.
REQ-032 Reset mid-HOLDOFF or mid-pipeline SHALL discard in-flight samples; first hit after reset requires a fresh sample at or above THRESH_ON.

Verification
REQ-033 Reset, enable=1, samples 0 for 10 consumes -> level 0, hit never, armed=1 from 2nd cycle after enable.
REQ-034 One consume with left[31:16]=16'h2710 (10000) -> level=10000 two cycles later, hit pulse next cycle, hit_count=1, state HOLDOFF.
REQ-035 HOLDOFF_CYCLES=8, env held >= 4000 past counter expiry -> stays HOLDOFF; feed zero samples until env<4000 -> ARMED next cycle; second 10000 sample -> hit_count=2.
REQ-036 left[31:16]=16'h8000 -> level=32767; env=10 with zero samples -> decays 10,9,8...0 one step per consume, then holds 0.
REQ-037 hit_count=255 plus further hit -> stays 255; clear_count coincident with hit -> hit_count=1.
REQ-038 enable dropped during HOLDOFF -> next cycle IDLE, read_audio_in 0, level 0, hit_count unchanged.
